host_xfer_ctrl: RTL and testbench
=================================

Name: host_xfer_ctrl

Overview:
- Parametrised host-transfer sequencer between the SPI word interface, one shared object RAM, and the subdivision engine.
- Loads a terminator-delimited word stream into RAM, then starts the engine and hands it the RAM port.
- After the engine finishes, streams the engine-reported word count back out, followed by the terminator.
- Successor to the fixed 32-bit, 11-bit-address top-level sequencer. Adds width/depth parameters, valid/ready handshakes, overflow and drop detection, and clean re-arm.

Parameters:
- DATA_W, 32, word width; must be a multiple of 8.
- ADDR_W, 11, RAM address width; DEPTH = 2**ADDR_W words.
- TERM_WORD, all-ones DATA_W, stream terminator value in both directions.

Ports:
- clk  in  1  system clock
- rstb  in  1  asynchronous active-low reset
- rx_valid  in  1  one-cycle pulse: rx_data holds a received word
- rx_data  in  DATA_W  received word
- tx_valid  out  1  tx_data holds a word to send
- tx_data  out  DATA_W  word to send
- tx_ready  in  1  transmitter consumes tx_data this cycle when tx_valid=1
- ram_en  out  1  RAM enable
- ram_we  out  DATA_W/8  RAM byte write enables
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data; 1-cycle latency
- eng_start  out  1  one-cycle engine start pulse
- eng_done  in  1  one-cycle engine completion pulse
- eng_word_count  in  ADDR_W+1  result length in words; sampled on eng_done
- eng_en, eng_we, eng_addr, eng_wdata  in  1, DATA_W/8, ADDR_W, DATA_W  engine RAM request
- eng_rdata  out  DATA_W  RAM read data forwarded to the engine
- busy  out  1  high in any state other than LOAD
- overflow  out  1  sticky: a LOAD word arrived when DEPTH words were already stored
- rx_drop  out  1  sticky: rx_valid arrived outside LOAD

Behaviour:
- Reset (rstb=0, async):
  - state=LOAD; wr_ptr, rd_ptr, out_cnt cleared.
  - All outputs 0: tx_valid, ram_en, ram_we, eng_start, busy, overflow, rx_drop.
  - Reset mid-transfer aborts immediately; RAM contents are don't-care.
- LOAD:
  - On rx_valid with rx_data != TERM_WORD and wr_ptr < DEPTH: same cycle drive ram_en=1, ram_we=all ones, ram_addr=wr_ptr, ram_wdata=rx_data; wr_ptr increments.
  - If wr_ptr == DEPTH: the word is discarded and overflow is set.
  - On rx_valid with rx_data == TERM_WORD: the word is not written; next state START.
  - rx_data is evaluated only when rx_valid=1.
- START:
  - eng_start=1 for exactly one cycle; next state RUN.
  - RAM mux switches to the engine from START through RUN.
- RUN:
  - ram_* = eng_*; eng_rdata = ram_rdata.
  - On eng_done: latch out_cnt = min(eng_word_count, DEPTH); rd_ptr=0; next state UNLOAD.
  - eng_done in any other state is ignored.
- UNLOAD:
  - Controller drives ram_en=1, ram_we=0, ram_addr=rd_ptr. Data is registered into tx_data one cycle later, then tx_valid=1.
  - tx_data holds stable while tx_valid && !tx_ready.
  - On each handshake: rd_ptr increments and the next read is issued. Maximum throughput is one word per 2 cycles.
  - After out_cnt handshakes, tx_data=TERM_WORD, tx_valid=1. On that handshake: tx_valid=0, wr_ptr=0, next state LOAD.
  - out_cnt=0: the terminator is sent directly.
- eng_rdata is 0 outside RUN/START.
- rx_valid outside LOAD sets rx_drop; the word is ignored.
- Sticky flags clear only on reset.
- Pointers are ADDR_W+1 bits wide, so no wrap-around.

Optional Feature:
- Macro XFER_CHECKSUM_EN.
- Defined:
  - A running XOR of all LOAD words is stored (terminator excluded).
  - In UNLOAD, after the out_cnt data words and before TERM_WORD, one extra word is sent: XOR of all transmitted data words.
  - New output rx_csum (DATA_W) holds the load XOR, valid from START until the next LOAD word.
- Undefined: no checksum word; rx_csum port absent.

Decomposition:
- Package xfer_pkg: state enum {LOAD, START, RUN, UNLOAD}; default TERM_WORD function of DATA_W; byte-enable width helper.
- Sub-module ram_port_mux: combinational controller/engine RAM arbitration selected by state.

Test Plan:
- Load 5 words 0x1..0x5, then 0xFFFFFFFF -> RAM[0..4]=1..5, exactly one eng_start pulse; engine idles 10 cycles then eng_done with count=3 -> tx sends RAM[0..2] then 0xFFFFFFFF; busy=0 afterwards.
- tx_ready held low 7 cycles mid-UNLOAD -> tx_data stable, no word skipped or repeated.
- ADDR_W=3: 9 words then terminator -> RAM holds the first 8; overflow=1; UNLOAD still works.
- eng_word_count=0 -> only 0xFFFFFFFF sent, return to LOAD; a second load/run/unload cycle succeeds from address 0.
- rx_valid pulses during RUN, plus rstb asserted mid-UNLOAD -> rx_drop=1; after reset all outputs 0, state LOAD.
- XFER_CHECKSUM_EN, load 0xA,0x5, count=2 -> rx_csum=0xF; tx sends 0xA, 0x5, 0xF, 0xFFFFFFFF.

Source files
------------

// File: rtl/host_xfer_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// xfer_pkg
// Shared types and helpers for the host-transfer sequencer.
//   xfer_state_e : top-level sequencer states (LOAD, START, RUN, UNLOAD)
//   tx_kind_e    : what the word currently presented on tx_data is
//   be_width()   : byte-enable width for a given data width
// The default terminator (all ones at DATA_W) is expressed directly as the
// TERM_WORD parameter default of host_xfer_ctrl.
// ---------------------------------------------------------------------------
package xfer_pkg;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_START  = 2'd1,
        ST_RUN    = 2'd2,
        ST_UNLOAD = 2'd3
    } xfer_state_e;

    typedef enum logic [1:0] {
        TX_DATA = 2'd0,
        TX_CSUM = 2'd1,
        TX_TERM = 2'd2
    } tx_kind_e;

    // Number of byte lanes in a data word.
    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/host_xfer_ctrl_ram_port_mux.sv
// ---------------------------------------------------------------------------
// ram_port_mux
// Combinational arbitration of the single object-RAM port between the
// sequencer (LOAD/UNLOAD) and the subdivision engine (START/RUN).
// Ports:
//   state                        current sequencer state (select)
//   ctrl_en/we/addr/wdata        sequencer RAM request
//   eng_en/we/addr/wdata         engine RAM request
//   ram_en/we/addr/wdata         RAM port
//   ram_rdata                    RAM read data
//   eng_rdata                    read data forwarded to the engine (0 when
//                                the engine does not own the port)
// ---------------------------------------------------------------------------
module ram_port_mux
    import xfer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 11
) (
    input  xfer_state_e                     state,
    input  logic                            ctrl_en,
    input  logic [be_width(DATA_W)-1:0]     ctrl_we,
    input  logic [ADDR_W-1:0]               ctrl_addr,
    input  logic [DATA_W-1:0]               ctrl_wdata,
    input  logic                            eng_en,
    input  logic [be_width(DATA_W)-1:0]     eng_we,
    input  logic [ADDR_W-1:0]               eng_addr,
    input  logic [DATA_W-1:0]               eng_wdata,
    output logic                            ram_en,
    output logic [be_width(DATA_W)-1:0]     ram_we,
    output logic [ADDR_W-1:0]               ram_addr,
    output logic [DATA_W-1:0]               ram_wdata,
    input  logic [DATA_W-1:0]               ram_rdata,
    output logic [DATA_W-1:0]               eng_rdata
);

    logic eng_owns_s;

    // Engine owns the port from the start pulse until it reports done.
    always_comb begin
        eng_owns_s = (state == ST_START) || (state == ST_RUN);
        if (eng_owns_s) begin
            ram_en    = eng_en;
            ram_we    = eng_we;
            ram_addr  = eng_addr;
            ram_wdata = eng_wdata;
            eng_rdata = ram_rdata;
        end else begin
            ram_en    = ctrl_en;
            ram_we    = ctrl_we;
            ram_addr  = ctrl_addr;
            ram_wdata = ctrl_wdata;
            eng_rdata = {DATA_W{1'b0}};
        end
    end

endmodule

// File: rtl/host_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// host_xfer_ctrl
// Host-transfer sequencer between the SPI word interface, the shared object
// RAM and the subdivision engine.
//   LOAD   : store a TERM_WORD-delimited rx word stream into RAM from addr 0
//   START  : one-cycle eng_start; engine takes over the RAM port
//   RUN    : engine owns the RAM; wait for eng_done, latch the result length
//   UNLOAD : stream min(count, DEPTH) RAM words out on tx, then TERM_WORD
// Ports:
//   clk, rstb                    clock, async active-low reset
//   rx_valid, rx_data            received word strobe / data
//   tx_valid, tx_data, tx_ready  transmit valid/ready handshake
//   ram_*                        shared object RAM port (1-cycle read latency)
//   eng_start, eng_done,
//   eng_word_count               engine control / result length
//   eng_en/we/addr/wdata/rdata   engine RAM request, forwarded read data
//   busy, overflow, rx_drop      status; overflow and rx_drop are sticky
// Build option XFER_CHECKSUM_EN: adds the rx_csum output (XOR of loaded
// words) and sends an XOR-of-transmitted-words checksum before TERM_WORD.
// ---------------------------------------------------------------------------
module host_xfer_ctrl
    import xfer_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 11,
    parameter logic [DATA_W-1:0] TERM_WORD = {DATA_W{1'b1}}
) (
    input  logic                            clk,
    input  logic                            rstb,
    input  logic                            rx_valid,
    input  logic [DATA_W-1:0]               rx_data,
    output logic                            tx_valid,
    output logic [DATA_W-1:0]               tx_data,
    input  logic                            tx_ready,
    output logic                            ram_en,
    output logic [be_width(DATA_W)-1:0]     ram_we,
    output logic [ADDR_W-1:0]               ram_addr,
    output logic [DATA_W-1:0]               ram_wdata,
    input  logic [DATA_W-1:0]               ram_rdata,
    output logic                            eng_start,
    input  logic                            eng_done,
    input  logic [ADDR_W:0]                 eng_word_count,
    input  logic                            eng_en,
    input  logic [be_width(DATA_W)-1:0]     eng_we,
    input  logic [ADDR_W-1:0]               eng_addr,
    input  logic [DATA_W-1:0]               eng_wdata,
    output logic [DATA_W-1:0]               eng_rdata,
    output logic                            busy,
    output logic                            overflow,
    output logic                            rx_drop
`ifdef XFER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0]               rx_csum
`endif
);

    localparam int              BE_W    = be_width(DATA_W);
    localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};

    xfer_state_e         state_r;
    xfer_state_e         state_nxt_s;
    logic [ADDR_W:0]     wr_ptr_r;
    logic [ADDR_W:0]     rd_ptr_r;
    logic [ADDR_W:0]     out_cnt_r;
    logic                tx_valid_r;
    logic [DATA_W-1:0]   tx_data_r;
    tx_kind_e            tx_kind_r;
    logic                kick_r;      // first UNLOAD cycle: nothing presented yet
    logic                cap_r;       // RAM read issued last cycle, capture now
    logic                overflow_r;
    logic                rx_drop_r;

    logic                rx_word_s;
    logic                rx_term_s;
    logic                load_wr_s;
    logic                tx_hs_s;
    logic                adv_s;
    logic                pre_data_s;
    logic [ADDR_W:0]     nxt_idx_s;
    logic                more_s;
    logic                rd_issue_s;
    logic                done_s;

    logic                ctrl_en_s;
    logic [BE_W-1:0]     ctrl_we_s;
    logic [ADDR_W-1:0]   ctrl_addr_s;
    logic [DATA_W-1:0]   ctrl_wdata_s;

`ifdef XFER_CHECKSUM_EN
    logic [DATA_W-1:0]   rx_csum_r;
    logic                load_fresh_r;  // next LOAD word starts a new checksum
    logic [DATA_W-1:0]   tx_xor_r;
    logic [DATA_W-1:0]   tx_xor_nxt_s;
`endif

    // Decode of the current-cycle events shared by FSM and datapath.
    always_comb begin
        rx_word_s  = rx_valid && (rx_data != TERM_WORD);
        rx_term_s  = rx_valid && (rx_data == TERM_WORD);
        load_wr_s  = (state_r == ST_LOAD) && rx_word_s && (wr_ptr_r != DEPTH_C);
        tx_hs_s    = tx_valid_r && tx_ready;
        // A new word is needed on entry to UNLOAD and after every handshake.
        adv_s      = (state_r == ST_UNLOAD) && (kick_r || tx_hs_s);
        pre_data_s = kick_r || (tx_kind_r == TX_DATA);
        if (kick_r) begin
            nxt_idx_s = {(ADDR_W+1){1'b0}};
        end else if (tx_kind_r == TX_DATA) begin
            nxt_idx_s = rd_ptr_r + ONE_C;
        end else begin
            nxt_idx_s = rd_ptr_r;
        end
        more_s     = pre_data_s && (nxt_idx_s < out_cnt_r);
        rd_issue_s = adv_s && more_s;
        done_s     = (state_r == ST_UNLOAD) && tx_hs_s && !kick_r && (tx_kind_r == TX_TERM);
    end

    // State register.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_r <= ST_LOAD;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_LOAD: begin
                if (rx_term_s) begin
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_START: begin
                state_nxt_s = ST_RUN;
            end
            ST_RUN: begin
                if (eng_done) begin
                    state_nxt_s = ST_UNLOAD;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_UNLOAD: begin
                if (done_s) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_UNLOAD;
                end
            end
            default: begin
                state_nxt_s = ST_LOAD;
            end
        endcase
    end

    // State-decoded outputs and the sequencer-side RAM request.
    always_comb begin
        eng_start    = (state_r == ST_START);
        busy         = (state_r != ST_LOAD);
        ctrl_en_s    = 1'b0;
        ctrl_we_s    = {BE_W{1'b0}};
        ctrl_addr_s  = {ADDR_W{1'b0}};
        ctrl_wdata_s = {DATA_W{1'b0}};
        case (state_r)
            ST_LOAD: begin
                if (load_wr_s) begin
                    ctrl_en_s    = 1'b1;
                    ctrl_we_s    = {BE_W{1'b1}};
                    ctrl_addr_s  = wr_ptr_r[ADDR_W-1:0];
                    ctrl_wdata_s = rx_data;
                end else begin
                    ctrl_en_s    = 1'b0;
                end
            end
            ST_UNLOAD: begin
                if (rd_issue_s) begin
                    ctrl_en_s    = 1'b1;
                    ctrl_addr_s  = nxt_idx_s[ADDR_W-1:0];
                end else begin
                    ctrl_en_s    = 1'b0;
                end
            end
            default: begin
                ctrl_en_s = 1'b0;
            end
        endcase
    end

    // Pointers, transmit register and sticky status flags.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wr_ptr_r   <= {(ADDR_W+1){1'b0}};
            rd_ptr_r   <= {(ADDR_W+1){1'b0}};
            out_cnt_r  <= {(ADDR_W+1){1'b0}};
            tx_valid_r <= 1'b0;
            tx_data_r  <= {DATA_W{1'b0}};
            tx_kind_r  <= TX_DATA;
            kick_r     <= 1'b0;
            cap_r      <= 1'b0;
            overflow_r <= 1'b0;
            rx_drop_r  <= 1'b0;
        end else begin
            kick_r <= (state_r == ST_RUN) && eng_done;
            if ((state_r != ST_LOAD) && rx_valid) begin
                rx_drop_r <= 1'b1;
            end
            case (state_r)
                ST_LOAD: begin
                    if (rx_word_s) begin
                        if (wr_ptr_r != DEPTH_C) begin
                            wr_ptr_r <= wr_ptr_r + ONE_C;
                        end else begin
                            overflow_r <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (eng_done) begin
                        out_cnt_r  <= (eng_word_count > DEPTH_C) ? DEPTH_C : eng_word_count;
                        rd_ptr_r   <= {(ADDR_W+1){1'b0}};
                        tx_valid_r <= 1'b0;
                        tx_kind_r  <= TX_DATA;
                        cap_r      <= 1'b0;
                    end
                end
                ST_UNLOAD: begin
                    if (cap_r) begin
                        tx_data_r  <= ram_rdata;
                        tx_valid_r <= 1'b1;
                        tx_kind_r  <= TX_DATA;
                        cap_r      <= 1'b0;
                    end else if (done_s) begin
                        tx_valid_r <= 1'b0;
                        tx_kind_r  <= TX_DATA;
                        wr_ptr_r   <= {(ADDR_W+1){1'b0}};
                    end else if (adv_s) begin
                        rd_ptr_r <= nxt_idx_s;
                        if (more_s) begin
                            // Read issued this cycle; word appears after capture.
                            tx_valid_r <= 1'b0;
                            cap_r      <= 1'b1;
                        end else begin
`ifdef XFER_CHECKSUM_EN
                            if (pre_data_s) begin
                                tx_data_r  <= tx_xor_nxt_s;
                                tx_valid_r <= 1'b1;
                                tx_kind_r  <= TX_CSUM;
                            end else begin
                                tx_data_r  <= TERM_WORD;
                                tx_valid_r <= 1'b1;
                                tx_kind_r  <= TX_TERM;
                            end
`else
                            tx_data_r  <= TERM_WORD;
                            tx_valid_r <= 1'b1;
                            tx_kind_r  <= TX_TERM;
`endif
                        end
                    end
                end
                default: begin
                    kick_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef XFER_CHECKSUM_EN
    // Checksum value including the data word handshaken this cycle.
    always_comb begin
        if (tx_hs_s && (tx_kind_r == TX_DATA)) begin
            tx_xor_nxt_s = tx_xor_r ^ tx_data_r;
        end else begin
            tx_xor_nxt_s = tx_xor_r;
        end
    end

    // Load-side and transmit-side running XOR checksums.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rx_csum_r    <= {DATA_W{1'b0}};
            load_fresh_r <= 1'b1;
            tx_xor_r     <= {DATA_W{1'b0}};
        end else begin
            if ((state_r == ST_LOAD) && rx_word_s) begin
                rx_csum_r    <= load_fresh_r ? rx_data : (rx_csum_r ^ rx_data);
                load_fresh_r <= 1'b0;
            end else if ((state_r == ST_LOAD) && rx_term_s) begin
                // An empty load reports a zero checksum.
                rx_csum_r    <= load_fresh_r ? {DATA_W{1'b0}} : rx_csum_r;
                load_fresh_r <= 1'b1;
            end
            if ((state_r == ST_RUN) && eng_done) begin
                tx_xor_r <= {DATA_W{1'b0}};
            end else if ((state_r == ST_UNLOAD) && tx_hs_s && (tx_kind_r == TX_DATA)) begin
                tx_xor_r <= tx_xor_r ^ tx_data_r;
            end
        end
    end

    assign rx_csum = rx_csum_r;
`endif

    assign tx_valid = tx_valid_r;
    assign tx_data  = tx_data_r;
    assign overflow = overflow_r;
    assign rx_drop  = rx_drop_r;

    ram_port_mux #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram_port_mux (
        .state      (state_r),
        .ctrl_en    (ctrl_en_s),
        .ctrl_we    (ctrl_we_s),
        .ctrl_addr  (ctrl_addr_s),
        .ctrl_wdata (ctrl_wdata_s),
        .eng_en     (eng_en),
        .eng_we     (eng_we),
        .eng_addr   (eng_addr),
        .eng_wdata  (eng_wdata),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .eng_rdata  (eng_rdata)
    );

endmodule

// File: tb/tb_host_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_host_xfer_ctrl
// Directed, table-driven bench for host_xfer_ctrl with a small RAM
// (ADDR_W=3, 8 words) so that overflow is reachable. LOAD phases are driven
// from a vector table; engine, unload and reset corners are hand sequences.
// ---------------------------------------------------------------------------
module tb_host_xfer_ctrl;

    localparam int DW = 32;
    localparam int AW = 3;
    localparam logic [31:0] TERM = 32'hFFFF_FFFF;

    logic            clk;
    logic            rstb;
    logic            rx_valid;
    logic [DW-1:0]   rx_data;
    logic            tx_valid;
    logic [DW-1:0]   tx_data;
    logic            tx_ready;
    logic            ram_en;
    logic [3:0]      ram_we;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_wdata;
    logic [DW-1:0]   ram_rdata;
    logic            eng_start;
    logic            eng_done;
    logic [AW:0]     eng_word_count;
    logic            eng_en;
    logic [3:0]      eng_we;
    logic [AW-1:0]   eng_addr;
    logic [DW-1:0]   eng_wdata;
    logic [DW-1:0]   eng_rdata;
    logic            busy;
    logic            overflow;
    logic            rx_drop;
`ifdef XFER_CHECKSUM_EN
    logic [DW-1:0]   rx_csum;
`endif

    host_xfer_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rstb(rstb),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .eng_start(eng_start), .eng_done(eng_done), .eng_word_count(eng_word_count),
        .eng_en(eng_en), .eng_we(eng_we), .eng_addr(eng_addr),
        .eng_wdata(eng_wdata), .eng_rdata(eng_rdata),
        .busy(busy), .overflow(overflow), .rx_drop(rx_drop)
`ifdef XFER_CHECKSUM_EN
        , .rx_csum(rx_csum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: byte-enabled write, registered read.
    logic [DW-1:0] mem [8];
    always @(posedge clk) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
            ram_rdata <= mem[ram_addr];
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        exp_en;
        logic [2:0]  exp_addr;
        logic        exp_ovf;
        logic        exp_busy;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] expq[$];

    task automatic add_vec(input logic [31:0] d, input logic en, input logic [2:0] addr,
                           input logic ovf, input logic bsy);
        vec_t t;
        t.v = 1'b1; t.d = d; t.exp_en = en; t.exp_addr = addr; t.exp_ovf = ovf; t.exp_busy = bsy;
        vecs.push_back(t);
    endtask

    // Apply the LOAD vector table, one rx word per cycle.
    task automatic run_vecs();
        foreach (vecs[i]) begin
            @(negedge clk);
            rx_valid = vecs[i].v;
            rx_data  = vecs[i].d;
            #1;
            check("load_ram_en", ram_en, vecs[i].exp_en);
            if (vecs[i].exp_en) begin
                check("load_ram_addr", ram_addr, vecs[i].exp_addr);
                check("load_ram_we", ram_we, 4'hF);
                check("load_ram_wdata", ram_wdata, vecs[i].d);
            end
            @(posedge clk);
            #1;
            rx_valid = 1'b0;
            check("load_overflow", overflow, vecs[i].exp_ovf);
            check("load_busy", busy, vecs[i].exp_busy);
        end
        vecs.delete();
    endtask

    // Append the optional checksum word and the terminator to expq.
    task automatic finish_exp();
        logic [31:0] x;
        x = 32'h0;
        foreach (expq[i]) x = x ^ expq[i];
`ifdef XFER_CHECKSUM_EN
        expq.push_back(x);
`endif
        expq.push_back(TERM);
    endtask

    // Engine model: count start pulses over a window, optionally read RAM
    // through the mux and inject a stray rx word, then report done.
    task automatic engine(input logic [3:0] cnt, input int win, input logic do_read,
                          input logic [2:0] raddr, input logic [31:0] rexp, input logic do_drop);
        int starts;
        starts = 0;
        for (int c = 0; c < win; c++) begin
            @(negedge clk);
            if (eng_start) starts++;
            if (do_read && c == 3) begin
                eng_en = 1'b1; eng_addr = raddr;
            end else if (do_read && c == 4) begin
                check("eng_rdata", eng_rdata, rexp);
                eng_en = 1'b0;
            end
            if (do_drop && c == 6) begin
                rx_valid = 1'b1; rx_data = 32'h0000_0099;
            end else if (do_drop && c == 7) begin
                rx_valid = 1'b0;
                check("rx_drop_set", rx_drop, 1'b1);
            end
        end
        check("eng_start_pulses", starts, 32'd1);
        @(negedge clk);
        eng_done = 1'b1; eng_word_count = cnt;
        @(negedge clk);
        eng_done = 1'b0;
    endtask

    // Receive the whole unload stream; optionally stall tx_ready at one word.
    task automatic collect(input int stall_at, input int stall_len);
        int idx, cyc, stall;
        logic done, stalled;
        logic [31:0] held;
        idx = 0; cyc = 0; stall = 0; done = 1'b0; stalled = 1'b0; held = 32'h0;
        tx_ready = 1'b1;
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (tx_valid) begin
                if (stall > 0) begin
                    check("tx_hold_data", tx_data, held);
                    stall--;
                    tx_ready = 1'b0;
                end else if (idx == stall_at && !stalled && stall_len > 0) begin
                    stalled = 1'b1;
                    held = tx_data;
                    stall = stall_len - 1;
                    tx_ready = 1'b0;
                end else begin
                    tx_ready = 1'b1;
                    check($sformatf("tx_word%0d", idx), tx_data, expq[idx]);
                    idx++;
                    if (idx == expq.size()) done = 1'b1;
                end
            end else begin
                tx_ready = 1'b1;
            end
        end
        check("unload_complete", done, 1'b1);
        @(negedge clk);
        tx_ready = 1'b0;
        check("unload_tx_valid_off", tx_valid, 1'b0);
        check("unload_busy_off", busy, 1'b0);
        expq.delete();
    endtask

    task automatic check_idle();
        check("idle_tx_valid", tx_valid, 1'b0);
        check("idle_ram_en", ram_en, 1'b0);
        check("idle_ram_we", ram_we, 4'h0);
        check("idle_eng_start", eng_start, 1'b0);
        check("idle_busy", busy, 1'b0);
        check("idle_overflow", overflow, 1'b0);
        check("idle_rx_drop", rx_drop, 1'b0);
        check("idle_eng_rdata", eng_rdata, 32'h0);
`ifdef XFER_CHECKSUM_EN
        check("idle_rx_csum", rx_csum, 32'h0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] x;
        rstb = 1'b0; rx_valid = 1'b0; rx_data = 32'h0; tx_ready = 1'b0;
        eng_done = 1'b0; eng_word_count = 4'h0; eng_en = 1'b0; eng_we = 4'h0;
        eng_addr = 3'h0; eng_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle();
        rstb = 1'b1;

        // Basic load of 1..5, engine count 3, unload with a 7-cycle stall.
        for (int i = 1; i <= 5; i++) add_vec(i, 1'b1, 3'(i - 1), 1'b0, 1'b0);
        add_vec(TERM, 1'b0, 3'h0, 1'b0, 1'b1);
        run_vecs();
        engine(4'd3, 12, 1'b1, 3'd2, 32'h3, 1'b0);
        for (int i = 0; i < 5; i++) check($sformatf("mem%0d", i), mem[i], 32'(i + 1));
        expq = {32'h1, 32'h2, 32'h3};
        finish_exp();
        collect(1, 7);

        // Overflow: 9 words into 8 entries; count 9 clamps to 8.
        for (int i = 0; i < 9; i++)
            add_vec(32'h11 + i, (i < 8), 3'(i), (i == 8), 1'b0);
        add_vec(TERM, 1'b0, 3'h0, 1'b1, 1'b1);
        run_vecs();
        engine(4'd9, 4, 1'b0, 3'd0, 32'h0, 1'b0);
        for (int i = 0; i < 8; i++) check($sformatf("ovf_mem%0d", i), mem[i], 32'h11 + i);
        for (int i = 0; i < 8; i++) expq.push_back(32'h11 + i);
        finish_exp();
        collect(-1, 0);

        // eng_done while in LOAD is ignored.
        @(negedge clk); eng_done = 1'b1; eng_word_count = 4'd2;
        @(negedge clk); eng_done = 1'b0;
        #1;
        check("done_in_load_busy", busy, 1'b0);

        // Zero-length result: only the trailer words are sent.
        add_vec(32'h77, 1'b1, 3'h0, 1'b1, 1'b0);
        add_vec(TERM, 1'b0, 3'h0, 1'b1, 1'b1);
        run_vecs();
        engine(4'd0, 4, 1'b0, 3'd0, 32'h0, 1'b0);
        finish_exp();
        collect(-1, 0);

        // Second cycle restarts at address 0; checksum 0xA ^ 0x5.
        add_vec(32'hA, 1'b1, 3'h0, 1'b1, 1'b0);
        add_vec(32'h5, 1'b1, 3'h1, 1'b1, 1'b0);
        add_vec(TERM, 1'b0, 3'h0, 1'b1, 1'b1);
        run_vecs();
`ifdef XFER_CHECKSUM_EN
        check("rx_csum", rx_csum, 32'hF);
`endif
        engine(4'd2, 6, 1'b1, 3'd1, 32'h5, 1'b0);
        expq = {32'hA, 32'h5};
        finish_exp();
        collect(-1, 0);
        check("no_spurious_drop", rx_drop, 1'b0);

        // rx during RUN sets rx_drop; reset mid-UNLOAD aborts.
        add_vec(32'h21, 1'b1, 3'h0, 1'b1, 1'b0);
        add_vec(32'h22, 1'b1, 3'h1, 1'b1, 1'b0);
        add_vec(TERM, 1'b0, 3'h0, 1'b1, 1'b1);
        run_vecs();
        engine(4'd2, 10, 1'b0, 3'd0, 32'h0, 1'b1);
        tx_ready = 1'b1;
        x = 32'h0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (tx_valid) begin
                x = tx_data;
                break;
            end
        end
        check("abort_first_word", x, 32'h21);
        @(negedge clk);
        check("abort_busy_before", busy, 1'b1);
        check("abort_overflow_sticky", overflow, 1'b1);
        check("abort_rx_drop_sticky", rx_drop, 1'b1);
        tx_ready = 1'b0;
        rstb = 1'b0;
        #1;
        check_idle();
        @(negedge clk);
        rstb = 1'b1;
        add_vec(32'h31, 1'b1, 3'h0, 1'b0, 1'b0);
        run_vecs();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
